// File: rtl/pac_input_if.sv
// Button, score and movement-request bundle between the board front end and the sprite mover.
interface pac_input_if;
    logic       btn_up;
    logic       btn_down;
    logic       btn_left;
    logic       btn_right;
    logic       btn_ctr;
    logic [3:0] score;
    logic       up;
    logic       down;
    logic       left;
    logic       right;
    logic       paused;
    logic       round_done;

    modport master (
        output btn_up, btn_down, btn_left, btn_right, btn_ctr, score,
        input  up, down, left, right, paused, round_done
    );

    modport slave (
        input  btn_up, btn_down, btn_left, btn_right, btn_ctr, score,
        output up, down, left, right, paused, round_done
    );
endinterface

// File: rtl/pac_input_ctrl.sv
// Pac-Man input front end: sync, debounce, press detect, latched direction, pause and round end.
// Optional PAC_HOLD_TO_MOVE_EN: move only while the direction button is held.
module pac_input_ctrl #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 16,
    parameter int WIN_SCORE       = 8
) (
    input  logic        clk_10,
    input  logic        rst,
    pac_input_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [3:0]       WIN_Q   = 4'(WIN_SCORE);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MOVING = 2'd1,
        ST_PAUSED = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Button bit order: [0] up, [1] down, [2] left, [3] right, [4] centre.
    logic [4:0]            raw_s;
    logic [4:0]            meta_q, sync_q;
    logic [4:0]            db_q, db_d, db_prev_q, press_q, press_d;
    logic [4:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]            dir_q, dir_d, dir_sel_s, move_s;
    logic [5:0]            out_q, out_d;
    state_t                state_q, state_d;

    assign raw_s = {bus.btn_ctr, bus.btn_right, bus.btn_left, bus.btn_down, bus.btn_up};

    // Debounce counters: a level must differ from db for DEBOUNCE_CYCLES straight cycles to be taken.
    always_comb begin
        db_d  = db_q;
        cnt_d = cnt_q;
        for (int i = 0; i < 5; i++) begin
            if (sync_q[i] == db_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                db_d[i]  = sync_q[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
        press_d = db_q & ~db_prev_q;
    end

    // Direction priority follows the mover's arbitration: up > right > left > down.
    always_comb begin
        if (press_q[0]) begin
            dir_sel_s = 4'b0001;
        end else if (press_q[3]) begin
            dir_sel_s = 4'b1000;
        end else if (press_q[2]) begin
            dir_sel_s = 4'b0100;
        end else if (press_q[1]) begin
            dir_sel_s = 4'b0010;
        end else begin
            dir_sel_s = 4'b0000;
        end
    end

    // Next state, direction and registered outputs; round end overrides any press.
    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        if ((state_q != ST_DONE) && (bus.score >= WIN_Q)) begin
            state_d = ST_DONE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (dir_sel_s != 4'b0000) begin
                        state_d = ST_MOVING;
                        dir_d   = dir_sel_s;
                    end else begin
                        dir_d   = 4'b0000;
                    end
                end
                ST_MOVING: begin
                    if (press_q[4]) begin
                        state_d = ST_PAUSED;
                    end else if (dir_sel_s != 4'b0000) begin
                        dir_d   = dir_sel_s;
`ifdef PAC_HOLD_TO_MOVE_EN
                    end else if ((dir_q & db_q[3:0]) == 4'b0000) begin
                        state_d = ST_IDLE;
                        dir_d   = 4'b0000;
`endif
                    end else begin
                        state_d = ST_MOVING;
                    end
                end
                ST_PAUSED: begin
                    if (press_q[4]) begin
                        state_d = ST_MOVING;
                    end else begin
                        state_d = ST_PAUSED;
                    end
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                end
                default: begin
                    state_d = ST_IDLE;
                    dir_d   = 4'b0000;
                end
            endcase
        end

        if (state_d == ST_MOVING) begin
`ifdef PAC_HOLD_TO_MOVE_EN
            move_s = dir_d & db_q[3:0];
`else
            move_s = dir_d;
`endif
        end else begin
            move_s = 4'b0000;
        end
        out_d = {(state_d == ST_DONE), (state_d == ST_PAUSED), move_s};
    end

    // Synchronizer, debounce and edge-detect registers.
    always_ff @(posedge clk_10 or posedge rst) begin
        if (rst) begin
            meta_q    <= 5'b00000;
            sync_q    <= 5'b00000;
            db_q      <= 5'b00000;
            db_prev_q <= 5'b00000;
            press_q   <= 5'b00000;
            cnt_q     <= '0;
        end else begin
            meta_q    <= raw_s;
            sync_q    <= meta_q;
            db_q      <= db_d;
            db_prev_q <= db_q;
            press_q   <= press_d;
            cnt_q     <= cnt_d;
        end
    end

    // State, direction and output registers.
    always_ff @(posedge clk_10 or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            dir_q   <= 4'b0000;
            out_q   <= 6'b000000;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            out_q   <= out_d;
        end
    end

    assign bus.up         = out_q[0];
    assign bus.down       = out_q[1];
    assign bus.left       = out_q[2];
    assign bus.right      = out_q[3];
    assign bus.paused     = out_q[4];
    assign bus.round_done = out_q[5];

endmodule

// File: tb/tb_pac_input_ctrl.sv
// Self-checking bench for pac_input_ctrl: directed scenarios plus random buttons/score
// checked against a window-based behavioural model.
module tb_pac_input_ctrl;

    localparam logic [4:0] B_NONE  = 5'b00000;
    localparam logic [4:0] B_UP    = 5'b00001;
    localparam logic [4:0] B_DOWN  = 5'b00010;
    localparam logic [4:0] B_LEFT  = 5'b00100;
    localparam logic [4:0] B_RIGHT = 5'b01000;
    localparam logic [4:0] B_CTR   = 5'b10000;

    // {round_done, paused, right, left, down, up}
    localparam logic [5:0] O_NONE   = 6'b000000;
    localparam logic [5:0] O_UP     = 6'b000001;
    localparam logic [5:0] O_DOWN   = 6'b000010;
    localparam logic [5:0] O_LEFT   = 6'b000100;
    localparam logic [5:0] O_RIGHT  = 6'b001000;
    localparam logic [5:0] O_PAUSED = 6'b010000;
    localparam logic [5:0] O_DONE   = 6'b100000;

    localparam int M_IDLE = 0, M_MOVING = 1, M_PAUSED = 2, M_DONE = 3;

    logic clk_10 = 1'b0;
    logic rst    = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    pac_input_if bus();

    pac_input_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (16),
        .WIN_SCORE      (8)
    ) dut (
        .clk_10(clk_10),
        .rst   (rst),
        .bus   (bus)
    );

    always #50 clk_10 = ~clk_10;

    // Reference model state
    logic [4:0] raw_hist[$];
    logic [4:0] rise_hist[$];
    logic [4:0] db_m;
    logic [3:0] m_dir;
    int         m_state;
    logic [5:0] m_out;

    task automatic check_eq(input string tag, input logic [5:0] got, input logic [5:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%b expected=%b at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [5:0] dut_outs();
        return {bus.round_done, bus.paused, bus.right, bus.left, bus.down, bus.up};
    endfunction

    task automatic model_reset();
        raw_hist.delete();
        rise_hist.delete();
        db_m    = 5'b00000;
        m_dir   = 4'b0000;
        m_state = M_IDLE;
        m_out   = O_NONE;
    endtask

    // A button's debounced level flips at edge n when the raw samples taken at edges
    // n-5..n-2 all hold the opposite level; the move logic acts on a rise two edges later.
    task automatic model_edge(input logic [4:0] raw, input logic [3:0] sc);
        logic [4:0] rises;
        logic [4:0] press;
        logic [3:0] sel;
        int         s;
        int         idx;
        bit         all1;
        bit         all0;
        logic       v;
        rises = 5'b00000;
        raw_hist.push_back(raw);
        if (raw_hist.size() > 8) void'(raw_hist.pop_front());
        s = raw_hist.size();
        for (int b = 0; b < 5; b++) begin
            all1 = 1'b1;
            all0 = 1'b1;
            for (int k = 2; k <= 5; k++) begin
                idx = s - 1 - k;
                v   = (idx >= 0) ? raw_hist[idx][b] : 1'b0;
                if (v) all0 = 1'b0;
                else   all1 = 1'b0;
            end
            if (all1 && !db_m[b]) begin
                db_m[b]  = 1'b1;
                rises[b] = 1'b1;
            end else if (all0 && db_m[b]) begin
                db_m[b] = 1'b0;
            end
        end
        rise_hist.push_back(rises);
        if (rise_hist.size() > 4) void'(rise_hist.pop_front());
        press = (rise_hist.size() >= 3) ? rise_hist[rise_hist.size() - 3] : 5'b00000;

        if      (press[0]) sel = 4'b0001;
        else if (press[3]) sel = 4'b1000;
        else if (press[2]) sel = 4'b0100;
        else if (press[1]) sel = 4'b0010;
        else               sel = 4'b0000;

        if (m_state != M_DONE && sc >= 4'd8) begin
            m_state = M_DONE;
        end else if (m_state == M_IDLE) begin
            if (sel != 4'b0000) begin
                m_state = M_MOVING;
                m_dir   = sel;
            end
        end else if (m_state == M_MOVING) begin
            if (press[4])                m_state = M_PAUSED;
            else if (sel != 4'b0000)     m_dir   = sel;
        end else if (m_state == M_PAUSED) begin
            if (press[4])                m_state = M_MOVING;
        end

        m_out = {(m_state == M_DONE), (m_state == M_PAUSED),
                 (m_state == M_MOVING) ? m_dir : 4'b0000};
    endtask

    task automatic step(input logic [4:0] raw, input logic [3:0] sc);
        @(negedge clk_10);
        {bus.btn_ctr, bus.btn_right, bus.btn_left, bus.btn_down, bus.btn_up} = raw;
        bus.score = sc;
        @(posedge clk_10);
        model_edge(raw, sc);
        #1;
        check_eq("model", dut_outs(), m_out);
    endtask

    task automatic hold(input logic [4:0] raw, input int n);
        for (int i = 0; i < n; i++) step(raw, 4'd0);
    endtask

    // Reset is raised between edges so outputs must clear with no clock involved.
    task automatic do_reset();
        @(negedge clk_10);
        #10;
        rst = 1'b1;
        #1;
        check_eq("async_rst", dut_outs(), O_NONE);
        {bus.btn_ctr, bus.btn_right, bus.btn_left, bus.btn_down, bus.btn_up} = B_NONE;
        bus.score = 4'd0;
        model_reset();
        @(posedge clk_10);
        #10;
        rst = 1'b0;
    endtask

    initial begin
        logic [4:0] cur;
        logic [3:0] sc;
        int         done_cnt;

        {bus.btn_ctr, bus.btn_right, bus.btn_left, bus.btn_down, bus.btn_up} = B_NONE;
        bus.score = 4'd0;
        model_reset();

        // Basic press latency and latching
        do_reset();
        hold(B_RIGHT, 7);
        check_eq("right_early", dut_outs(), O_NONE);
        hold(B_RIGHT, 1);
        check_eq("right_lat7", dut_outs(), O_RIGHT);
        hold(B_NONE, 6);
        check_eq("right_latched", dut_outs(), O_RIGHT);

        // Glitch rejection, then the shortest accepted press
        do_reset();
        hold(B_UP, 3);
        hold(B_NONE, 10);
        check_eq("glitch", dut_outs(), O_NONE);
        hold(B_UP, 4);
        hold(B_NONE, 3);
        check_eq("up_early", dut_outs(), O_NONE);
        hold(B_NONE, 1);
        check_eq("up_lat7", dut_outs(), O_UP);

        // Priority and replacement
        do_reset();
        hold(B_UP | B_LEFT, 8);
        check_eq("prio_up_left", dut_outs(), O_UP);
        hold(B_NONE, 6);
        hold(B_DOWN, 7);
        check_eq("down_early", dut_outs(), O_UP);
        hold(B_DOWN, 1);
        check_eq("down_replace", dut_outs(), O_DOWN);

        // Pause / resume
        do_reset();
        hold(B_LEFT, 8);
        check_eq("left_move", dut_outs(), O_LEFT);
        hold(B_NONE, 6);
        hold(B_CTR, 8);
        check_eq("pause", dut_outs(), O_PAUSED);
        hold(B_NONE, 6);
        hold(B_RIGHT, 8);
        hold(B_NONE, 6);
        check_eq("pause_ignore", dut_outs(), O_PAUSED);
        hold(B_CTR, 8);
        check_eq("resume", dut_outs(), O_LEFT);

        // Round end
        step(B_NONE, 4'd8);
        check_eq("round_done", dut_outs(), O_DONE);
        hold(B_UP, 8);
        hold(B_NONE, 6);
        check_eq("done_sticky", dut_outs(), O_DONE);
        do_reset();
        hold(B_NONE, 1);
        check_eq("after_done", dut_outs(), O_NONE);

        // Async reset while moving, then full latency again
        hold(B_RIGHT, 8);
        check_eq("right_again", dut_outs(), O_RIGHT);
        do_reset();
        hold(B_RIGHT, 7);
        check_eq("post_rst_early", dut_outs(), O_NONE);
        hold(B_RIGHT, 1);
        check_eq("post_rst_lat7", dut_outs(), O_RIGHT);

        // Random buttons and score against the model
        cur      = B_NONE;
        done_cnt = 0;
        for (int i = 0; i < 4000; i++) begin
            for (int b = 0; b < 5; b++) begin
                if ($urandom_range(0, 5) == 0) cur[b] = ~cur[b];
            end
            if ($urandom_range(0, 399) == 0) sc = 4'($urandom_range(8, 15));
            else                             sc = 4'($urandom_range(0, 7));
            step(cur, sc);
            if (m_state == M_DONE) done_cnt++;
            if (done_cnt >= 10 || $urandom_range(0, 999) == 0) begin
                do_reset();
                done_cnt = 0;
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/pac_input_ctrl.md
Name: pac_input_ctrl

Overview:
- Front end for the Pac-Man movement logic.
- Takes the four raw board direction buttons plus a centre button, then synchronizes, debounces and edge-detects them.
- Drives a latched one-hot direction (up/down/left/right) into the sprite mover, so Pac-Man keeps moving after the button is released.
- Also owns pause and end-of-round freeze, using the cookie score fed back from the sprite.

Parameters:
- DEBOUNCE_CYCLES, 16, consecutive clk_10 cycles a synchronized button level must hold before the debounced level changes; legal range 1..65535.
- CNT_W, 16, debounce counter width; must hold DEBOUNCE_CYCLES-1.
- WIN_SCORE, 8, score value at which the round ends (all 8 cookies eaten).

Ports:
- clk_10  input  1  system clock for the block.
- rst  input  1  reset, asynchronous, active-high.
- btn_up  input  1  raw up button, asynchronous to clk_10.
- btn_down  input  1  raw down button, asynchronous.
- btn_left  input  1  raw left button, asynchronous.
- btn_right  input  1  raw right button, asynchronous.
- btn_ctr  input  1  raw centre button (pause toggle), asynchronous.
- score  input  4  cookies eaten, fed back from the sprite mover.
- up  output  1  move-up request.
- down  output  1  move-down request.
- left  output  1  move-left request.
- right  output  1  move-right request.
- paused  output  1  high in PAUSED state.
- round_done  output  1  high in DONE state.

Behaviour:
- Reset: rst asynchronous, active-high; clock clk_10.
  - Asserting rst clears all synchronizers, debounced levels, counters, edge registers and the direction register, and forces state IDLE.
  - All outputs are 0 in reset, including mid-movement, mid-pause and DONE.
- Synchronizer: each of the 5 buttons passes through a 2-flop synchronizer; sync output is s_x.
- Debounce, per button:
  - Counter cnt_x and debounced level db_x.
  - If s_x == db_x: cnt_x <= 0.
  - Else if cnt_x == DEBOUNCE_CYCLES-1: db_x <= s_x and cnt_x <= 0.
  - Else: cnt_x <= cnt_x+1.
  - A glitch shorter than DEBOUNCE_CYCLES clocks is fully rejected; the counter restarts on any return to db_x.
- Edge detect: press_x is a registered pulse, 1 when db_x is 1 and its previous-cycle value was 0. Releases generate nothing.
- Latency: a clean raw press held steady produces press_x, and the direction register updates, at rising edge DEBOUNCE_CYCLES+3 after the first edge that samples the new raw level. Every test uses this exact value.
- Direction priority when several press pulses fall in one cycle: up > right > left > down. This matches the mover's arbitration order.
- Direction register dir[3:0] is one-hot or zero. Outputs are driven from registers, so at most one of up/down/left/right is ever high.
- State machine:
  - IDLE: dir = 0, all direction outputs 0.
    - Any direction press -> MOVING with dir set to that direction.
    - Centre press is ignored.
  - MOVING: the output for dir is held high continuously.
    - A new direction press replaces dir the same cycle (reversal allowed).
    - Centre press -> PAUSED; dir is retained.
  - PAUSED: all direction outputs 0; paused = 1.
    - Direction presses are ignored and do not change dir.
    - Centre press -> MOVING with the retained dir.
  - DONE: all direction outputs 0; round_done = 1. Leaves only on rst.
  - Any state except DONE: score >= WIN_SCORE (unsigned 4-bit compare) -> DONE on the next edge. This transition wins over any simultaneous press.
- Same-cycle centre and direction press in MOVING: pause wins; the direction press is discarded.
- Same-cycle centre and direction press in IDLE: the direction wins (goes to MOVING).
- score is treated as quasi-static; no synchronizer. It must come from the clk_10 domain.

Optional Feature:
- Macro PAC_HOLD_TO_MOVE_EN.
- Defined:
  - In MOVING, the direction output is gated by the current debounced level of that button, so Pac-Man moves only while the button is held.
  - Release of the held button, once debounced, returns the block to IDLE and clears dir.
  - Pause and DONE behave as below.
- Undefined (default): latched-direction behaviour as specified above; releases have no effect.

Test Plan:
- All tests run with DEBOUNCE_CYCLES=4.
- Reset / basic press: rst pulse, then btn_right held high from edge 0 -> right=1 at edge 7, up/down/left=0. Release btn_right -> right stays 1.
- Glitch reject: btn_up high for 3 cycles, then low -> up never asserts; state stays IDLE. Repeat with 4 stable cycles -> up=1 at edge 7.
- Priority / replace: btn_up and btn_left pressed on the same edge from IDLE -> up=1, left=0. Later btn_down press -> down=1 at its edge 7, up=0 in the same cycle.
- Pause: in MOVING with left=1, press btn_ctr -> left=0, paused=1. Press btn_right while paused -> no change. Press btn_ctr again -> left=1, paused=0.
- Round end: in MOVING, drive score=8 -> next edge round_done=1 and all directions 0. Button presses are then ignored. rst -> round_done=0, IDLE.
- Async reset mid-operation: assert rst between clock edges while right=1 -> right=0 immediately (no clock). After release, a new press gives the full 7-edge latency.
